aaxi_arbiter: RTL and testbench

N-to-1 arbiter for the aaxi request/response bus. It merges N upstream masters onto one downstream aaxi slave port with round-robin arbitration. Up to DEPTH requests may be in flight at once, and each response is routed back to the master that issued it. It sits on the single-clock side of the fabric, downstream of the async bridges, where several local masters share one peripheral bus.

---
 rtl/aaxi_arbiter.sv | 127 ++++++++++++
 tb/tb_aaxi_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aaxi_arbiter.sv
// aaxi_arbiter: N-to-1 round-robin arbiter for the aaxi request/response bus.
// Merges N upstream masters onto one downstream slave port. Up to DEPTH
// requests may be outstanding; responses come back in issue order and are
// routed to the issuing master through an ID FIFO.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_avalid/s_aready         per-master request handshake (s_aready is combinational)
//   s_awe/s_aaddr/s_adata/s_astrb  per-master request payload, packed by index
//   s_bvalid/s_bdata          registered response pulse and shared response data
//   m_avalid/m_aready         downstream request handshake (registered request slot)
//   m_awe/m_aaddr/m_adata/m_astrb  downstream request payload
//   m_bvalid/m_bdata          downstream in-order response
module aaxi_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      s_avalid,
  output logic [N-1:0]      s_aready,
  input  logic [N-1:0]      s_awe,
  input  logic [N*30-1:0]   s_aaddr,
  input  logic [N*32-1:0]   s_adata,
  input  logic [N*4-1:0]    s_astrb,
  output logic [N-1:0]      s_bvalid,
  output logic [31:0]       s_bdata,
  output logic              m_avalid,
  input  logic              m_aready,
  output logic              m_awe,
  output logic [29:0]       m_aaddr,
  output logic [31:0]       m_adata,
  output logic [3:0]        m_astrb,
  input  logic              m_bvalid,
  input  logic [31:0]       m_bdata
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0] rr;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] head;
  logic          gnt_found;
  logic          slot_free;
  logic          grant;
  logic          pop;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [IW-1:0] id_fifo [DEPTH];

  // Pointer wrap works for any DEPTH, including 1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin search starting at rr, wrapping modulo N.
  always_comb begin
    int j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 0; k < int'(N); k++) begin
      j = int'(rr) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (!gnt_found && s_avalid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(j);
      end
    end
  end

  assign slot_free = !m_avalid || m_aready;
  assign grant     = !rst && slot_free && (cnt < CW'(DEPTH)) && gnt_found;
  assign pop       = m_bvalid && (cnt != '0);
  assign s_aready  = grant ? (N'(1) << gnt_idx) : '0;
  assign head      = id_fifo[rptr];

  // Request slot, round-robin pointer, outstanding count and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_avalid <= 1'b0;
      m_awe    <= 1'b0;
      m_aaddr  <= '0;
      m_adata  <= '0;
      m_astrb  <= '0;
      s_bvalid <= '0;
      s_bdata  <= '0;
      rr       <= '0;
      cnt      <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      if (grant) begin
        m_avalid <= 1'b1;
        m_awe    <= s_awe[gnt_idx];
        m_aaddr  <= s_aaddr[int'(gnt_idx)*30 +: 30];
        m_adata  <= s_adata[int'(gnt_idx)*32 +: 32];
        m_astrb  <= s_astrb[int'(gnt_idx)*4 +: 4];
        rr       <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        wptr     <= ptr_inc(wptr);
      end else if (slot_free) begin
        m_avalid <= 1'b0;
      end

      // Response with nothing outstanding is a protocol violation: dropped.
      s_bvalid <= pop ? (N'(1) << head) : '0;
      if (pop) begin
        s_bdata <= m_bdata;
        rptr    <= ptr_inc(rptr);
      end

      case ({grant, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // ID FIFO storage; occupancy always equals cnt, so no overflow check is needed.
  always_ff @(posedge clk) begin
    if (grant) id_fifo[wptr] <= gnt_idx;
  end

endmodule

// File: tb/tb_aaxi_arbiter.sv
// Directed testbench for aaxi_arbiter (N=2, DEPTH=4).
module tb_aaxi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_avalid;
  logic [1:0]  s_aready;
  logic [1:0]  s_awe;
  logic [59:0] s_aaddr;
  logic [63:0] s_adata;
  logic [7:0]  s_astrb;
  logic [1:0]  s_bvalid;
  logic [31:0] s_bdata;
  logic        m_avalid;
  logic        m_aready;
  logic        m_awe;
  logic [29:0] m_aaddr;
  logic [31:0] m_adata;
  logic [3:0]  m_astrb;
  logic        m_bvalid;
  logic [31:0] m_bdata;

  int n_checks = 0;
  int n_pass   = 0;

  aaxi_arbiter #(.N(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_avalid(s_avalid), .s_aready(s_aready), .s_awe(s_awe),
    .s_aaddr(s_aaddr), .s_adata(s_adata), .s_astrb(s_astrb),
    .s_bvalid(s_bvalid), .s_bdata(s_bdata),
    .m_avalid(m_avalid), .m_aready(m_aready), .m_awe(m_awe),
    .m_aaddr(m_aaddr), .m_adata(m_adata), .m_astrb(m_astrb),
    .m_bvalid(m_bvalid), .m_bdata(m_bdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [29:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    s_awe[i]           = we;
    s_aaddr[30*i +: 30] = addr;
    s_adata[32*i +: 32] = data;
    s_astrb[4*i +: 4]   = strb;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_avalid = '0;
    m_bvalid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_rdy [4];
    logic [1:0] exp_bv  [4];
    rst = 1'b1; s_avalid = '0; s_awe = '0; s_aaddr = '0; s_adata = '0; s_astrb = '0;
    m_aready = 1'b1; m_bvalid = 1'b0; m_bdata = '0;
    tick();
    tick();

    // Reset state
    check("rst_m_avalid", 32'(m_avalid), 32'd0);
    check("rst_s_bvalid", 32'(s_bvalid), 32'd0);
    check("rst_s_bdata", s_bdata, 32'd0);
    check("rst_m_aaddr", 32'(m_aaddr), 32'd0);
    s_avalid = 2'b01;
    #1 check("rst_s_aready", 32'(s_aready), 32'd0);

    // Single master write
    rst = 1'b0;
    set_req(0, 1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
    #1 check("t1_aready", 32'(s_aready), 32'h1);
    tick();
    s_avalid = 2'b00;
    check("t1_m_avalid", 32'(m_avalid), 32'd1);
    check("t1_m_awe", 32'(m_awe), 32'd1);
    check("t1_m_aaddr", 32'(m_aaddr), 32'h10);
    check("t1_m_adata", m_adata, 32'hDEADBEEF);
    check("t1_m_astrb", 32'(m_astrb), 32'hF);
    tick();
    check("t1_m_avalid_drop", 32'(m_avalid), 32'd0);
    tick();
    tick();
    m_bvalid = 1'b1; m_bdata = 32'h0;
    tick();
    m_bvalid = 1'b0;
    check("t1_s_bvalid", 32'(s_bvalid), 32'h1);
    check("t1_s_bdata", s_bdata, 32'h0);
    tick();
    check("t1_s_bvalid_pulse", 32'(s_bvalid), 32'h0);

    // Round-robin fairness with prompt responses
    do_reset();
    set_req(0, 1'b0, 30'h100, 32'h11, 4'h1);
    set_req(1, 1'b0, 30'h200, 32'h22, 4'h2);
    s_avalid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      m_bvalid = (i > 0);
      m_bdata  = 32'(i);
      #1 check("t2_aready", 32'(s_aready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check("t2_m_aaddr", 32'(m_aaddr), (i % 2 == 0) ? 32'h100 : 32'h200);
      if (i > 0) check("t2_s_bvalid", 32'(s_bvalid), (i % 2 == 1) ? 32'h1 : 32'h2);
    end
    s_avalid = 2'b00;
    m_bvalid = 1'b1;
    tick();
    m_bvalid = 1'b0;
    check("t2_s_bvalid_last", 32'(s_bvalid), 32'h2);
    tick();

    // Backpressure and full
    do_reset();
    set_req(0, 1'b1, 30'h300, 32'h33, 4'h3);
    set_req(1, 1'b1, 30'h400, 32'h44, 4'h4);
    m_aready = 1'b0;
    s_avalid = 2'b11;
    #1 check("t3_first_aready", 32'(s_aready), 32'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1 check("t3_bp_aready", 32'(s_aready), 32'h0);
      tick();
      check("t3_bp_m_avalid", 32'(m_avalid), 32'd1);
      check("t3_bp_m_aaddr", 32'(m_aaddr), 32'h300);
    end
    m_aready = 1'b1;
    exp_rdy[0] = 2'b10; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_rel_aready", 32'(s_aready), 32'(exp_rdy[i]));
      tick();
      check("t3_rel_m_aaddr", 32'(m_aaddr), (exp_rdy[i] == 2'b01) ? 32'h300 : 32'h400);
    end
    #1 check("t3_full_aready", 32'(s_aready), 32'h0);
    tick();
    check("t3_full_m_avalid", 32'(m_avalid), 32'd0);
    check("t3_full_aready2", 32'(s_aready), 32'h0);
    tick();
    m_bvalid = 1'b1; m_bdata = 32'hA0;
    #1 check("t3_no_bypass", 32'(s_aready), 32'h0);
    tick();
    m_bvalid = 1'b0;
    check("t3_s_bvalid", 32'(s_bvalid), 32'h1);
    check("t3_s_bdata", s_bdata, 32'hA0);
    #1 check("t3_regrant", 32'(s_aready), 32'h1);
    tick();
    s_avalid = 2'b00;
    check("t3_regrant_addr", 32'(m_aaddr), 32'h300);
    exp_bv[0] = 2'b10; exp_bv[1] = 2'b01; exp_bv[2] = 2'b10; exp_bv[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      m_bvalid = 1'b1; m_bdata = 32'hB0 + 32'(i);
      tick();
      check("t3_drain_bvalid", 32'(s_bvalid), 32'(exp_bv[i]));
      check("t3_drain_bdata", s_bdata, 32'hB0 + 32'(i));
    end
    m_bvalid = 1'b0;
    tick();

    // In-order routing: issue m0, m1, m1, m0
    do_reset();
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b10; exp_rdy[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      s_avalid = exp_rdy[i];
      #1 check("t4_aready", 32'(s_aready), 32'(exp_rdy[i]));
      tick();
    end
    s_avalid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      m_bvalid = 1'b1; m_bdata = 32'(i + 1);
      tick();
      check("t4_bvalid", 32'(s_bvalid), 32'(exp_rdy[i]));
      check("t4_bdata", s_bdata, 32'(i + 1));
    end
    m_bvalid = 1'b0;
    tick();
    check("t4_bvalid_idle", 32'(s_bvalid), 32'h0);

    // Reset with three outstanding, then spurious response
    do_reset();
    s_avalid = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    s_avalid = 2'b00;
    rst = 1'b1;
    tick();
    check("t5_m_avalid", 32'(m_avalid), 32'd0);
    check("t5_m_awe", 32'(m_awe), 32'd0);
    check("t5_m_aaddr", 32'(m_aaddr), 32'd0);
    check("t5_m_adata", m_adata, 32'd0);
    check("t5_m_astrb", 32'(m_astrb), 32'd0);
    check("t5_s_bvalid", 32'(s_bvalid), 32'd0);
    check("t5_s_bdata", s_bdata, 32'd0);
    rst = 1'b0;
    m_bvalid = 1'b1; m_bdata = 32'h55;
    tick();
    m_bvalid = 1'b0;
    check("t5_spurious", 32'(s_bvalid), 32'h0);
    check("t5_spurious_data", s_bdata, 32'h0);
    s_avalid = 2'b10;
    #1 check("t5_new_aready", 32'(s_aready), 32'h2);
    tick();
    s_avalid = 2'b00;
    check("t5_new_addr", 32'(m_aaddr), 32'h400);
    m_bvalid = 1'b1; m_bdata = 32'h77;
    tick();
    m_bvalid = 1'b0;
    check("t5_new_bvalid", 32'(s_bvalid), 32'h2);
    check("t5_new_bdata", s_bdata, 32'h77);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
